// File: rtl/rst_sync_seq.sv
// Reset synchroniser and sequencer: async-assert/sync-release, then releases NUM_CH channel resets in order.
// Optional soft restart of the hold/release sequence is built when RST_SEQ_SOFT_EN is defined.
//
// state   | meaning
// --------+--------------------------------------------------------------
// ASSERT  | all channels held; waiting for the synchroniser output to go high
// HOLD    | counting the hold time before channel 0 is released
// RELEASE | releasing one channel per STEP_CYCLES, in index order
// DONE    | every channel released; stays here until a reset
module rst_sync_seq #(
    parameter int NUM_Stages  = 2,
    parameter int NUM_CH      = 3,
    parameter int HOLD_CYCLES = 8,
    parameter int STEP_CYCLES = 4
) (
    input  logic              CLK,
    input  logic              Async_Reset,
    input  logic              soft_rst_req,
    output logic [NUM_CH-1:0] sync_Reset,
    output logic              rst_done
);

    localparam int MAX_CYC = (HOLD_CYCLES > STEP_CYCLES) ? HOLD_CYCLES : STEP_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);
    localparam int IDX_W   = $clog2(NUM_CH + 1);

    // The first hold starts one edge late (the edge that sees the synchroniser go high),
    // so it loads one less than a soft restart does.
    localparam logic [CNT_W-1:0] HOLD_LD_FIRST = CNT_W'((HOLD_CYCLES >= 2) ? (HOLD_CYCLES - 2) : 0);
    localparam logic [CNT_W-1:0] HOLD_LD_SOFT  = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] STEP_LD       = CNT_W'(STEP_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_IDX      = IDX_W'(NUM_CH - 1);

    typedef enum logic [1:0] {
        ST_ASSERT  = 2'd0,
        ST_HOLD    = 2'd1,
        ST_RELEASE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    logic [NUM_Stages-1:0] chain_q, chain_d;
    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [NUM_CH-1:0]     rst_q, rst_d;
    logic                  done_q, done_d;

    logic                  sync_out;
    logic                  soft_req;
    logic                  rel_go;
    logic [NUM_CH-1:0]     rst_shift;

`ifdef RST_SEQ_SOFT_EN
    assign soft_req = soft_rst_req;
`else
    logic unused_soft;
    assign unused_soft = soft_rst_req;
    assign soft_req    = 1'b0;
`endif

    assign sync_out = chain_q[NUM_Stages-1];

    always_comb begin
        chain_d = {chain_q[NUM_Stages-2:0], 1'b1};
    end

    // Channels are released as a thermometer, so a later channel can never rise first.
    always_comb begin
        rst_shift    = '0;
        rst_shift[0] = 1'b1;
        for (int k = 1; k < NUM_CH; k++) begin
            rst_shift[k] = rst_q[k-1];
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        rst_d   = rst_q;
        done_d  = done_q;
        rel_go  = 1'b0;

        case (state_q)
            ST_ASSERT: begin
                if (sync_out) begin
                    if (HOLD_CYCLES == 1) begin
                        rel_go = 1'b1;
                    end else begin
                        state_d = ST_HOLD;
                        cnt_d   = HOLD_LD_FIRST;
                    end
                end
            end
            ST_HOLD, ST_RELEASE: begin
                if (cnt_q == '0) begin
                    rel_go = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_ASSERT;
            end
        endcase

        if (rel_go) begin
            rst_d = rst_shift;
            if (idx_q == LAST_IDX) begin
                state_d = ST_DONE;
                done_d  = 1'b1;
            end else begin
                state_d = ST_RELEASE;
                idx_d   = idx_q + IDX_W'(1);
                cnt_d   = STEP_LD;
            end
        end

        // Soft restart re-enters HOLD with all channels held; the synchroniser is left alone.
        if (soft_req && (state_q != ST_ASSERT)) begin
            state_d = ST_HOLD;
            cnt_d   = HOLD_LD_SOFT;
            idx_d   = '0;
            rst_d   = '0;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge Async_Reset) begin
        if (!Async_Reset) begin
            chain_q <= '0;
            state_q <= ST_ASSERT;
            cnt_q   <= '0;
            idx_q   <= '0;
            rst_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            chain_q <= chain_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            rst_q   <= rst_d;
            done_q  <= done_d;
        end
    end

    assign sync_Reset = rst_q;
    assign rst_done   = done_q;

endmodule

// File: tb/tb_rst_sync_seq.sv
// Directed bench for rst_sync_seq: expected output timelines are queued from release-time formulas
// and popped one per clock; RST_SEQ_SOFT_EN selects the soft-reset expectations.
module tb_rst_sync_seq;

    localparam int TB_STAGES = 2;
    localparam int TB_HOLD   = 8;
    localparam int TB_STEP   = 4;

    logic       CLK;
    logic       Async_Reset;
    logic       soft_rst_req;
    logic [2:0] sync_Reset;
    logic       rst_done;
    logic       rst2;
    logic [0:0] sync2;
    logic       done2;

    int n_assert = 0;
    int n_fail   = 0;

    string      tag_q[$];
    logic [3:0] exp_q[$];

    rst_sync_seq #(
        .NUM_Stages (TB_STAGES),
        .NUM_CH     (3),
        .HOLD_CYCLES(TB_HOLD),
        .STEP_CYCLES(TB_STEP)
    ) dut (
        .CLK         (CLK),
        .Async_Reset (Async_Reset),
        .soft_rst_req(soft_rst_req),
        .sync_Reset  (sync_Reset),
        .rst_done    (rst_done)
    );

    rst_sync_seq #(
        .NUM_Stages (4),
        .NUM_CH     (1),
        .HOLD_CYCLES(1),
        .STEP_CYCLES(4)
    ) dut_min (
        .CLK         (CLK),
        .Async_Reset (rst2),
        .soft_rst_req(1'b0),
        .sync_Reset  (sync2),
        .rst_done    (done2)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: bench did not finish, observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Entry n is the expected {rst_done, sync_Reset} after the n-th edge counted from the
    // reference edge; channel k is released once n reaches base + k*STEP.
    task automatic push_seq(input string tag, input int base, input int first, input int count);
        for (int i = 0; i < count; i++) begin
            int         n;
            logic [3:0] e;
            n    = first + i;
            e[0] = (n >= base);
            e[1] = (n >= base + TB_STEP);
            e[2] = (n >= base + 2 * TB_STEP);
            e[3] = (n >= base + 2 * TB_STEP);
            tag_q.push_back($sformatf("%s_n%0d", tag, n));
            exp_q.push_back(e);
        end
    endtask

    task automatic push_const(input string tag, input logic [3:0] v, input int count);
        for (int i = 0; i < count; i++) begin
            tag_q.push_back($sformatf("%s_%0d", tag, i));
            exp_q.push_back(v);
        end
    endtask

    task automatic run_check(input int cycles, input bit use_min);
        for (int i = 0; i < cycles; i++) begin
            logic [3:0] obs;
            @(posedge CLK);
            #1;
            obs = use_min ? {2'b00, done2, sync2[0]} : {rst_done, sync_Reset};
            n_assert++;
            assert (exp_q.size() != 0) else begin
                n_fail++;
                $error("FAIL scoreboard_empty observed=%b expected=queued_entry", obs);
            end
            if (exp_q.size() != 0) begin
                check(tag_q.pop_front(), obs, exp_q.pop_front());
            end
        end
    endtask

    initial begin
        Async_Reset  = 1'b0;
        soft_rst_req = 1'b0;
        rst2         = 1'b0;

        // Power-up: reset low for three edges, released before E1.
        repeat (3) @(posedge CLK);
        #1;
        check("por_reset", {rst_done, sync_Reset}, 4'b0000);
        check("min_reset", {2'b00, done2, sync2[0]}, 4'b0000);
        Async_Reset = 1'b1;
        push_seq("pwr", TB_STAGES + TB_HOLD, 1, 20);
        run_check(20, 1'b0);

        // Sub-cycle glitch while DONE clears everything without a clock edge.
        #3;
        Async_Reset = 1'b0;
        #2;
        Async_Reset = 1'b1;
        #1;
        check("glitch_clear", {rst_done, sync_Reset}, 4'b0000);
        push_seq("glitch", TB_STAGES + TB_HOLD, 1, 20);
        run_check(20, 1'b0);

        // Restart, then reset again between E12 and E13 with only ch0 released.
        Async_Reset = 1'b0;
        #1;
        check("mid_pre_clear", {rst_done, sync_Reset}, 4'b0000);
        @(posedge CLK);
        #1;
        Async_Reset = 1'b1;
        push_seq("mid_a", TB_STAGES + TB_HOLD, 1, 12);
        run_check(12, 1'b0);
        #2;
        Async_Reset = 1'b0;
        #1;
        check("mid_clear", {rst_done, sync_Reset}, 4'b0000);
        push_const("mid_held", 4'b0000, 2);
        run_check(2, 1'b0);
        Async_Reset = 1'b1;
        push_seq("mid_b", TB_STAGES + TB_HOLD, 1, 20);
        run_check(20, 1'b0);

        // Soft reset from DONE: single-cycle request, then a request held for five edges.
`ifdef RST_SEQ_SOFT_EN
        soft_rst_req = 1'b1;
        push_seq("soft1", TB_HOLD, 0, 18);
        run_check(1, 1'b0);
        soft_rst_req = 1'b0;
        run_check(17, 1'b0);

        soft_rst_req = 1'b1;
        push_seq("soft_held", TB_HOLD + 4, 0, 22);
        run_check(5, 1'b0);
        soft_rst_req = 1'b0;
        run_check(17, 1'b0);
`else
        soft_rst_req = 1'b1;
        push_const("soft_off1", 4'b1111, 18);
        run_check(1, 1'b0);
        soft_rst_req = 1'b0;
        run_check(17, 1'b0);

        soft_rst_req = 1'b1;
        push_const("soft_off_held", 4'b1111, 22);
        run_check(5, 1'b0);
        soft_rst_req = 1'b0;
        run_check(17, 1'b0);
`endif

        // Single channel, 4-deep synchroniser, hold of one: ch0 and rst_done rise after E5.
        check("min_still_reset", {2'b00, done2, sync2[0]}, 4'b0000);
        rst2 = 1'b1;
        for (int n = 1; n <= 8; n++) begin
            tag_q.push_back($sformatf("min_n%0d", n));
            exp_q.push_back({2'b00, (n >= 5), (n >= 5)});
        end
        run_check(8, 1'b1);

        n_assert++;
        assert (exp_q.size() == 0) else begin
            n_fail++;
            $error("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
